// File: rtl/i2s_tdm_tx_pkg.sv
// i2s_pkg: shared types and helpers for the I2S / TDM transmitter.
//   i2s_state_t  - transmitter FSM state (IDLE, RUN)
//   I2S_MODE_*   - framing mode selectors for the LJ_MODE parameter
//   slot_bit()   - maps a frame position to a pad flag and sample bit index
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;

    localparam int I2S_MODE_I2S = 0;
    localparam int I2S_MODE_LJ  = 1;

    typedef struct packed {
        logic       pad;  // position lies in the zero padding of the slot
        logic [4:0] idx;  // sample bit index (MSB first), valid when !pad
    } slot_bit_t;

    function automatic slot_bit_t slot_bit(input int p, input int slot_w, input int data_w);
        slot_bit_t r;
        int        b;
        b     = p % slot_w;
        r.pad = (b >= data_w);
        r.idx = r.pad ? 5'd0 : 5'(data_w - 1 - b);
        return r;
    endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// i2s_tdm_tx_if: frame input channel of the transmitter.
//   s_data_i  - CHANNELS*DATA_W frame, channel 0 in bits [DATA_W-1:0]
//   s_valid_i - source has a frame on s_data_i
//   s_ready_o - transmitter can take a frame this cycle
// Handshake: a frame moves when s_valid_i && s_ready_o are both high at a
// rising sclk edge. The source holds s_data_i stable while s_valid_i is high
// and not yet accepted. s_ready_o never depends combinationally on s_valid_i.
interface i2s_tdm_tx_if #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*DATA_W-1:0] s_data_i;
    logic                       s_valid_i;
    logic                       s_ready_o;

    modport master (output s_data_i, output s_valid_i, input s_ready_o);
    modport slave  (input s_data_i, input s_valid_i, output s_ready_o);
endinterface

// File: rtl/i2s_tdm_tx_frame_buffer.sv
// i2s_frame_buffer: single-entry holding register in front of the shifter.
//   sclk_i, rst_i - bit clock, synchronous active-high reset
//   s_if          - frame input channel (slave side)
//   pop           - shifter takes the held frame this cycle
//   full          - holding register contains a frame
//   data          - held frame
module i2s_frame_buffer #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2
) (
    input  logic                       sclk_i,
    input  logic                       rst_i,
    i2s_tdm_tx_if.slave                s_if,
    input  logic                       pop,
    output logic                       full,
    output logic [CHANNELS*DATA_W-1:0] data
);
    logic push;

    // The register counts as empty during the cycle it is popped, so a new
    // frame can be accepted on the same edge the shifter loads the old one.
    assign s_if.s_ready_o = !full || pop;
    assign push           = s_if.s_valid_i && s_if.s_ready_o;

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            full <= 1'b0;
            data <= '0;
        end else if (push) begin
            data <= s_if.s_data_i;
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S / left-justified / TDM serial transmitter.
//   sclk_i         - bit clock, all logic on rising edge
//   rst_i          - synchronous active-high reset
//   en_i           - enable, sampled in IDLE and at frame end
//   s_if           - frame input channel (valid/ready)
//   ws_o           - word select (low for first half of the slots)
//   sdata_o        - serial data, MSB first
//   frame_start_o  - pulse during frame position 0
//   underrun_o     - pulse at position 0 of a frame reloaded with zeros
//   underrun_cnt_o - saturating underrun count
//   state_o        - FSM state, for observation
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 16,
    parameter int CHANNELS = 2,
    parameter int LJ_MODE  = I2S_MODE_I2S
) (
    input  logic       sclk_i,
    input  logic       rst_i,
    input  logic       en_i,
    i2s_tdm_tx_if.slave s_if,
    output logic       ws_o,
    output logic       sdata_o,
    output logic       frame_start_o,
    output logic       underrun_o,
    output logic [7:0] underrun_cnt_o,
    output i2s_state_t state_o
);
    localparam int F       = CHANNELS * SLOT_W;
    localparam int POS_W   = $clog2(F);
    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int SEL_W   = $clog2(FRAME_W);

    i2s_state_t       state_q, state_n;
    logic [POS_W-1:0] pos_q, pos_n;     // position currently on the outputs
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic             load, starve, pop;
    logic             buf_full;
    logic [FRAME_W-1:0] buf_data;
    slot_bit_t        sb;
    int               slot_n;
    logic [SEL_W-1:0] sel;
    logic             ws_n, bit_n;
    logic             ws_q, bit_q, dly_q, fs_q, ur_q;
    logic [7:0]       cnt_q;

    i2s_frame_buffer #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) u_buf (
        .sclk_i (sclk_i),
        .rst_i  (rst_i),
        .s_if   (s_if),
        .pop    (pop),
        .full   (buf_full),
        .data   (buf_data)
    );

    always_comb begin
        state_n = state_q;
        pos_n   = pos_q;
        load    = 1'b0;
        starve  = 1'b0;
        case (state_q)
            IDLE: begin
                pos_n = '0;
                if (en_i && buf_full) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (pos_q == POS_W'(F - 1)) begin
                    pos_n = '0;
                    if (!en_i) begin
                        state_n = IDLE;
                    end else begin
                        load   = 1'b1;
                        starve = !buf_full;
                    end
                end else begin
                    pos_n = pos_q + POS_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop = load && buf_full;

    // Outputs are computed for the position about to be entered, so each
    // position appears in the cycle right after the edge that selects it.
    always_comb begin
        frame_n = frame_q;
        if (load) frame_n = buf_full ? buf_data : '0;
        sb     = slot_bit(int'(pos_n), SLOT_W, DATA_W);
        slot_n = int'(pos_n) / SLOT_W;
        sel    = SEL_W'(slot_n * DATA_W + int'(sb.idx));
        ws_n   = (state_n == RUN) && (slot_n >= CHANNELS / 2);
        bit_n  = (state_n == RUN) && !sb.pad && frame_n[sel];
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pos_q   <= '0;
            frame_q <= '0;
            ws_q    <= 1'b0;
            bit_q   <= 1'b0;
            dly_q   <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_n;
            pos_q   <= pos_n;
            frame_q <= frame_n;
            ws_q    <= ws_n;
            bit_q   <= bit_n;
            dly_q   <= bit_q;  // I2S one-bit data delay
            fs_q    <= load;
            ur_q    <= starve;
            if (starve && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign ws_o           = ws_q;
    assign sdata_o        = (LJ_MODE == I2S_MODE_LJ) ? bit_q : dly_q;
    assign frame_start_o  = fs_q;
    assign underrun_o     = ur_q;
    assign underrun_cnt_o = cnt_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_i2s_tdm_tx.sv
module tb_i2s_tdm_tx;
    import i2s_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    i2s_tdm_tx_if #(.DATA_W(16), .CHANNELS(2)) if_a ();
    i2s_tdm_tx_if #(.DATA_W(24), .CHANNELS(4)) if_b ();

    logic       ws_a, sd_a, fs_a, ur_a, ws_b, sd_b, fs_b, ur_b;
    logic [7:0] cnt_a, cnt_b;
    i2s_state_t st_a, st_b;

    i2s_tdm_tx #(.DATA_W(16), .SLOT_W(16), .CHANNELS(2), .LJ_MODE(I2S_MODE_I2S)) dut_a (
        .sclk_i(clk), .rst_i(rst), .en_i(en_a), .s_if(if_a.slave),
        .ws_o(ws_a), .sdata_o(sd_a), .frame_start_o(fs_a), .underrun_o(ur_a),
        .underrun_cnt_o(cnt_a), .state_o(st_a)
    );

    i2s_tdm_tx #(.DATA_W(24), .SLOT_W(32), .CHANNELS(4), .LJ_MODE(I2S_MODE_LJ)) dut_b (
        .sclk_i(clk), .rst_i(rst), .en_i(en_b), .s_if(if_b.slave),
        .ws_o(ws_b), .sdata_o(sd_b), .frame_start_o(fs_b), .underrun_o(ur_b),
        .underrun_cnt_o(cnt_b), .state_o(st_b)
    );

    // scoreboard: expected serial stream for the back-to-back run
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one stereo frame from IDLE, drop enable at p=5, check the whole
    // frame plus the trailing IDLE cycle that carries the last LSB.
    task automatic i2s_single_frame(input string tag, input logic [31:0] frame);
        logic [32:0] sd_exp;
        sd_exp = {1'b0, frame[15:0], frame[31:16]};
        chk({tag, " ready idle"}, 32'(if_a.s_ready_o), 32'd1);
        en_a = 1'b1;
        if_a.s_data_i  = frame;
        if_a.s_valid_i = 1'b1;
        @(negedge clk);
        if_a.s_valid_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k <= 32; k++) begin
            chk($sformatf("%s ws p%0d", tag, k), 32'(ws_a), 32'((k < 32) && (k >= 16)));
            chk($sformatf("%s sd p%0d", tag, k), 32'(sd_a), 32'(sd_exp[32-k]));
            chk($sformatf("%s fs p%0d", tag, k), 32'(fs_a), 32'(k == 0));
            if (k == 5) en_a = 1'b0;
            @(negedge clk);
        end
        chk({tag, " idle state"}, 32'(st_a), 32'(IDLE));
        chk({tag, " idle ws"}, 32'(ws_a), 32'd0);
        chk({tag, " idle sd"}, 32'(sd_a), 32'd0);
    endtask

    logic [63:0]  b2b_stream;
    logic [127:0] tdm_stream;
    logic [0:0]   e;

    initial begin
        rst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        if_a.s_valid_i = 1'b0;
        if_a.s_data_i  = '0;
        if_b.s_valid_i = 1'b0;
        if_b.s_data_i  = '0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst ready", 32'(if_a.s_ready_o), 32'd1);
        chk("rst ws", 32'(ws_a), 32'd0);
        chk("rst sd", 32'(sd_a), 32'd0);
        chk("rst fs", 32'(fs_a), 32'd0);
        chk("rst ur", 32'(ur_a), 32'd0);
        chk("rst cnt", 32'(cnt_a), 32'd0);
        chk("rst state", 32'(st_a), 32'(IDLE));
        chk("rst b ready", 32'(if_b.s_ready_o), 32'd1);
        chk("rst b ws", 32'(ws_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic I2S framing with enable drop at p=5; channel 0 = DEAD
        i2s_single_frame("basic", 32'hBEEF_DEAD);

        // back-to-back frames followed by starvation
        b2b_stream = 64'hBEEF_DEAD_FABB_CABB;
        for (int k = 0; k < 96; k++) begin
            e[0] = (k >= 1 && k <= 64) ? b2b_stream[64-k] : 1'b0;
            exp_q.push_back(e);
        end
        en_a = 1'b1;
        if_a.s_data_i  = 32'hDEAD_BEEF;
        if_a.s_valid_i = 1'b1;
        @(negedge clk);
        chk("b2b ready at load", 32'(if_a.s_ready_o), 32'd1);
        if_a.s_data_i = 32'hCABB_FABB;
        @(negedge clk);
        if_a.s_valid_i = 1'b0;
        for (int k = 0; k < 96; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("b2b sd k%0d", k), 32'(sd_a), 32'(e));
            chk($sformatf("b2b ws k%0d", k), 32'(ws_a), 32'((k % 32) >= 16));
            chk($sformatf("b2b fs k%0d", k), 32'(fs_a), 32'((k % 32) == 0));
            chk($sformatf("b2b ready k%0d", k), 32'(if_a.s_ready_o), 32'(k >= 31));
            chk($sformatf("b2b ur k%0d", k), 32'(ur_a), 32'(k == 64));
            if (k == 63 || k == 64 || k == 95)
                chk($sformatf("b2b cnt k%0d", k), 32'(cnt_a), (k == 63) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        // now at p=0 of frame 4 (second underrun); 300 more starved frames
        repeat (300 * 32) @(negedge clk);
        chk("sat cnt", 32'(cnt_a), 32'd255);
        chk("sat ur", 32'(ur_a), 32'd1);
        chk("sat fs", 32'(fs_a), 32'd1);
        en_a = 1'b0;
        repeat (32) @(negedge clk);
        chk("sat idle state", 32'(st_a), 32'(IDLE));
        chk("sat idle ws", 32'(ws_a), 32'd0);
        repeat (40) @(negedge clk);
        chk("idle no count", 32'(cnt_a), 32'd255);
        chk("idle no ur", 32'(ur_a), 32'd0);

        // reset mid-frame with the holding register full
        en_a = 1'b1;
        if_a.s_data_i  = 32'h1234_5678;
        if_a.s_valid_i = 1'b1;
        @(negedge clk);
        if_a.s_data_i = 32'h9ABC_DEF0;
        @(negedge clk);
        if_a.s_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid state", 32'(st_a), 32'(RUN));
        chk("mid ready", 32'(if_a.s_ready_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst ready", 32'(if_a.s_ready_o), 32'd1);
        chk("mrst ws", 32'(ws_a), 32'd0);
        chk("mrst sd", 32'(sd_a), 32'd0);
        chk("mrst fs", 32'(fs_a), 32'd0);
        chk("mrst ur", 32'(ur_a), 32'd0);
        chk("mrst cnt", 32'(cnt_a), 32'd0);
        chk("mrst state", 32'(st_a), 32'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post rst no start", 32'(st_a), 32'(IDLE));
        chk("post rst sd", 32'(sd_a), 32'd0);
        i2s_single_frame("post_rst", 32'h0F0F_A5A5);

        // TDM left-justified, 24-bit samples in 32-bit slots
        tdm_stream = 128'hA5A5A500_12345600_FFFFFF00_00000100;
        en_b = 1'b1;
        if_b.s_data_i  = 96'h000001_FFFFFF_123456_A5A5A5;
        if_b.s_valid_i = 1'b1;
        @(negedge clk);
        if_b.s_valid_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k <= 128; k++) begin
            chk($sformatf("tdm ws p%0d", k), 32'(ws_b), 32'((k < 128) && (k >= 64)));
            chk($sformatf("tdm sd p%0d", k), 32'(sd_b), (k < 128) ? 32'(tdm_stream[127-k]) : 32'd0);
            chk($sformatf("tdm fs p%0d", k), 32'(fs_b), 32'(k == 0));
            if (k == 5) en_b = 1'b0;
            @(negedge clk);
        end
        chk("tdm idle state", 32'(st_b), 32'(IDLE));
        chk("tdm ur", 32'(ur_b), 32'd0);
        chk("tdm cnt", 32'(cnt_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
